// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: the only driver of the register-file write port.
// It merges in-order WB writes with late MDU results. An MDU result that
// collides with a WB write waits in a small FIFO until a free slot.
// A younger WB write to the same register kills the queued entry.
module rf_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_wn,
  input  logic [31:0] pipe_d,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_wn,
  input  logic [31:0] mdu_d,
  output logic        we,
  output logic [4:0]  wn,
  output logic [31:0] d,
  output logic [CW-1:0] q_count,
  input  logic [4:0]  pend_rs,
  input  logic [4:0]  pend_rt,
  output logic        pend_rs_hit,
  output logic        pend_rt_hit
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic        vld;
    logic        live;
    logic [4:0]  wn;
    logic [31:0] d;
  } ent_t;

  ent_t          q [DEPTH];
  logic [AW-1:0] rptr, wptr;

  logic pipe_req, acc, mdu_nz, empty, pop, byp, push, push_live;
  ent_t head;

  // Ready is taken from the registered count, so a pop cannot raise it in the same cycle.
  assign mdu_ready = (q_count < CW'(DEPTH));

  assign head      = q[rptr];
  assign pipe_req  = pipe_we && (pipe_wn != 5'd0);
  assign acc       = mdu_valid && mdu_ready;
  assign mdu_nz    = (mdu_wn != 5'd0);
  assign empty     = (q_count == '0);
  assign pop       = !pipe_req && !empty;
  assign byp       = !pipe_req && empty && acc && mdu_nz;
  assign push      = acc && mdu_nz && !byp;
  // An MDU result arriving with a WB write to the same register is the older one.
  assign push_live = !(pipe_req && (pipe_wn == mdu_wn));

  // Hazard lookup: report any queued result that is still live, skipping r0.
  always_comb begin
    pend_rs_hit = 1'b0;
    pend_rt_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].vld && q[i].live && (q[i].wn == pend_rs) && (pend_rs != 5'd0))
        pend_rs_hit = 1'b1;
      if (q[i].vld && q[i].live && (q[i].wn == pend_rt) && (pend_rt != 5'd0))
        pend_rt_hit = 1'b1;
    end
  end

  // Write-port selection, FIFO update and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we      <= 1'b0;
      wn      <= 5'd0;
      d       <= 32'd0;
      q_count <= '0;
      rptr    <= '0;
      wptr    <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      if (pipe_req) begin
        we <= 1'b1;
        wn <= pipe_wn;
        d  <= pipe_d;
      end else if (pop) begin
        // A killed head still uses one slot and produces a bubble.
        we <= head.live;
        if (head.live) begin
          wn <= head.wn;
          d  <= head.d;
        end
      end else if (byp) begin
        we <= 1'b1;
        wn <= mdu_wn;
        d  <= mdu_d;
      end else begin
        we <= 1'b0;
      end

      for (int i = 0; i < DEPTH; i++)
        if (pipe_req && q[i].vld && (q[i].wn == pipe_wn)) q[i].live <= 1'b0;

      if (pop) begin
        q[rptr].vld  <= 1'b0;
        q[rptr].live <= 1'b0;
        rptr         <= rptr + AW'(1);
      end

      // Push cannot target the head slot, because accepting needs a non-full FIFO.
      if (push) begin
        q[wptr] <= '{vld: 1'b1, live: push_live, wn: mdu_wn, d: mdu_d};
        wptr    <= wptr + AW'(1);
      end

      case ({push, pop})
        2'b10:   q_count <= q_count + CW'(1);
        2'b01:   q_count <= q_count - CW'(1);
        default: q_count <= q_count;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a negedge-commit register-file model.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_wn;
  logic [31:0] pipe_d;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_wn;
  logic [31:0] mdu_d;
  logic        we;
  logic [4:0]  wn;
  logic [31:0] d;
  logic [1:0]  q_count;
  logic [4:0]  pend_rs, pend_rt;
  logic        pend_rs_hit, pend_rt_hit;

  int vectors = 0;
  int errs    = 0;

  logic [31:0] rf [32];

  rf_write_arbiter #(.DEPTH(2), .CW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_wn(pipe_wn), .pipe_d(pipe_d),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_wn(mdu_wn), .mdu_d(mdu_d),
    .we(we), .wn(wn), .d(d), .q_count(q_count),
    .pend_rs(pend_rs), .pend_rt(pend_rt),
    .pend_rs_hit(pend_rs_hit), .pend_rt_hit(pend_rt_hit)
  );

  always #5 clk = ~clk;

  // Register file commits on the negedge following the output update.
  initial for (int i = 0; i < 32; i++) rf[i] = 32'd0;
  always @(negedge clk) if (we === 1'b1) rf[wn] <= d;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pipe(input logic v, input logic [4:0] n, input logic [31:0] x);
    pipe_we = v; pipe_wn = n; pipe_d = x;
  endtask

  task automatic mdu(input logic v, input logic [4:0] n, input logic [31:0] x);
    mdu_valid = v; mdu_wn = n; mdu_d = x;
  endtask

  initial begin
    rst_n = 1'b0;
    pipe(1'b1, 5'd4, 32'h1);
    mdu(1'b0, 5'd0, 32'd0);
    pend_rs = 5'd0; pend_rt = 5'd0;

    // Reset held two cycles with a pipe request present
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_qc", 32'(q_count), 32'd0);
      chk("rst_rdy", 32'(mdu_ready), 32'd1);
    end
    chk("rst_wn", 32'(wn), 32'd0);
    chk("rst_d", d, 32'd0);
    rst_n = 1'b1;
    pipe(1'b0, 5'd0, 32'd0);
    tick();
    chk("idle_we", 32'(we), 32'd0);

    // Pipe pass-through
    pipe(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    chk("pt_we", 32'(we), 32'd1);
    chk("pt_wn", 32'(wn), 32'd5);
    chk("pt_d", d, 32'hDEADBEEF);
    pipe(1'b0, 5'd0, 32'd0);
    @(negedge clk); #1;
    chk("pt_rf5", rf[5], 32'hDEADBEEF);

    // Collision then drain
    pipe(1'b1, 5'd3, 32'h11);
    mdu(1'b1, 5'd7, 32'h22);
    pend_rs = 5'd7;
    tick();
    chk("col_wn", 32'(wn), 32'd3);
    chk("col_d", d, 32'h11);
    chk("col_qc", 32'(q_count), 32'd1);
    chk("col_hit", 32'(pend_rs_hit), 32'd1);
    pipe(1'b0, 5'd0, 32'd0);
    mdu(1'b0, 5'd0, 32'd0);
    tick();
    chk("drn_we", 32'(we), 32'd1);
    chk("drn_wn", 32'(wn), 32'd7);
    chk("drn_d", d, 32'h22);
    chk("drn_qc", 32'(q_count), 32'd0);
    chk("drn_hit", 32'(pend_rs_hit), 32'd0);
    tick();
    chk("hold_we", 32'(we), 32'd0);
    chk("hold_wn", 32'(wn), 32'd7);
    chk("hold_d", d, 32'h22);
    chk("rf3", rf[3], 32'h11);

    // Bypass: idle pipe, empty FIFO
    mdu(1'b1, 5'd15, 32'h77);
    tick();
    chk("byp_we", 32'(we), 32'd1);
    chk("byp_wn", 32'(wn), 32'd15);
    chk("byp_d", d, 32'h77);
    chk("byp_qc", 32'(q_count), 32'd0);

    // Full / backpressure with pipe busy every cycle
    pipe(1'b1, 5'd10, 32'h1);
    mdu(1'b1, 5'd11, 32'hA1);
    tick();
    chk("ful_qc1", 32'(q_count), 32'd1);
    chk("ful_rdy1", 32'(mdu_ready), 32'd1);
    pipe(1'b1, 5'd10, 32'h2);
    mdu(1'b1, 5'd12, 32'hA2);
    tick();
    chk("ful_qc2", 32'(q_count), 32'd2);
    chk("ful_rdy2", 32'(mdu_ready), 32'd0);
    pipe(1'b1, 5'd10, 32'h3);
    mdu(1'b1, 5'd13, 32'hA3);
    tick();
    chk("ful_qc3", 32'(q_count), 32'd2);
    chk("ful_rdy3", 32'(mdu_ready), 32'd0);
    chk("ful_d3", d, 32'h3);
    pipe(1'b0, 5'd0, 32'd0);
    tick();
    chk("bp_wn1", 32'(wn), 32'd11);
    chk("bp_d1", d, 32'hA1);
    chk("bp_qc1", 32'(q_count), 32'd1);
    chk("bp_rdy1", 32'(mdu_ready), 32'd1);
    tick();
    chk("bp_wn2", 32'(wn), 32'd12);
    chk("bp_d2", d, 32'hA2);
    chk("bp_qc2", 32'(q_count), 32'd1);
    mdu(1'b0, 5'd0, 32'd0);
    tick();
    chk("bp_we3", 32'(we), 32'd1);
    chk("bp_wn3", 32'(wn), 32'd13);
    chk("bp_d3", d, 32'hA3);
    chk("bp_qc3", 32'(q_count), 32'd0);

    // Kill ordering
    pend_rs = 5'd9;
    pipe(1'b1, 5'd20, 32'h5);
    mdu(1'b1, 5'd9, 32'hAA);
    tick();
    chk("kil_qc", 32'(q_count), 32'd1);
    chk("kil_hit1", 32'(pend_rs_hit), 32'd1);
    pipe(1'b1, 5'd9, 32'hBB);
    mdu(1'b0, 5'd0, 32'd0);
    tick();
    chk("kil_wn", 32'(wn), 32'd9);
    chk("kil_hit0", 32'(pend_rs_hit), 32'd0);
    chk("kil_qc2", 32'(q_count), 32'd1);
    pipe(1'b0, 5'd0, 32'd0);
    tick();
    chk("kil_bub", 32'(we), 32'd0);
    chk("kil_qc0", 32'(q_count), 32'd0);
    tick();
    chk("kil_rf9", rf[9], 32'hBB);

    // Same-cycle pipe and MDU to one register: queued entry is dead on arrival
    pend_rt = 5'd14;
    pipe(1'b1, 5'd14, 32'h1);
    mdu(1'b1, 5'd14, 32'h2);
    tick();
    chk("sc_qc", 32'(q_count), 32'd1);
    chk("sc_hit", 32'(pend_rt_hit), 32'd0);
    pipe(1'b0, 5'd0, 32'd0);
    mdu(1'b0, 5'd0, 32'd0);
    tick();
    chk("sc_bub", 32'(we), 32'd0);
    tick();
    chk("sc_rf14", rf[14], 32'h1);

    // Zero register requests
    pend_rs = 5'd0;
    pipe(1'b1, 5'd0, 32'h99);
    mdu(1'b1, 5'd0, 32'h98);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("z_we", 32'(we), 32'd0);
      chk("z_qc", 32'(q_count), 32'd0);
      chk("z_rdy", 32'(mdu_ready), 32'd1);
      chk("z_hit", 32'(pend_rs_hit), 32'd0);
    end

    // Reset mid-drain discards queued results
    pipe(1'b1, 5'd21, 32'h7);
    mdu(1'b1, 5'd22, 32'hC1);
    tick();
    mdu(1'b1, 5'd23, 32'hC2);
    tick();
    chk("rd_qc", 32'(q_count), 32'd2);
    pipe(1'b0, 5'd0, 32'd0);
    mdu(1'b0, 5'd0, 32'd0);
    rst_n = 1'b0;
    tick();
    chk("rd_we", 32'(we), 32'd0);
    chk("rd_qc0", 32'(q_count), 32'd0);
    chk("rd_rdy", 32'(mdu_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    chk("rd_we2", 32'(we), 32'd0);
    tick();
    chk("rd_rf22", rf[22], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
